count_capture_unit: RTL and testbench

- Downstream consumer of the free-running 6-bit binary counter and its 1-bit `result` output.
- Timestamps rising edges of an event line (driven by the counter's `result`) with {wrap epoch, count}.
- Buffers timestamps in a small first-word-fall-through (FWFT) FIFO drained via valid/ready.
- Also flags compare matches and counter wrap-arounds for the control logic.

---
 rtl/count_capture_pkg.sv | 13 +
 rtl/count_capture_unit_fifo.sv | 61 ++++++
 rtl/count_capture_unit.sv | 103 ++++++++++
 tb/tb_count_capture_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_capture_pkg.sv
// Shared widths and the capture-entry layout for the count capture unit.
package count_capture_pkg;

  localparam int COUNT_W = 6;
  localparam int WRAP_W  = 4;
  localparam int CAP_W   = WRAP_W + COUNT_W;

  typedef struct packed {
    logic [WRAP_W-1:0]  wrap_epoch;
    logic [COUNT_W-1:0] count;
  } cap_entry_t;

endpackage

// File: rtl/count_capture_unit_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible whenever non-empty.
module capture_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pop_en;
  logic             wr_en;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_W'(DEPTH));
  assign level     = level_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  always_comb begin
    pop_en   = pop & ~empty;
    wr_en    = push & (~full | pop_en);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_en);
    level_d  = level_q + LVL_W'(wr_en) - LVL_W'(pop_en);
    mem_d    = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/count_capture_unit.sv
// Timestamps event rising edges with {wrap epoch, count}, flags compare hits and counter wraps.
module count_capture_unit
  import count_capture_pkg::*;
#(
  parameter int COUNT_W    = count_capture_pkg::COUNT_W,
  parameter int WRAP_W     = count_capture_pkg::WRAP_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [COUNT_W-1:0]            count_in,
  input  logic                          event_in,
  input  logic                          cmp_en,
  input  logic [COUNT_W-1:0]            cmp_value,
  input  logic                          cap_ready,
  input  logic                          clear_ovf,
  output logic                          cap_valid,
  output logic [WRAP_W+COUNT_W-1:0]     cap_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          cmp_match,
  output logic                          wrap_pulse,
  output logic                          overflow
);

  localparam int ENTRY_W = WRAP_W + COUNT_W;

  logic               primed_q, primed_d;
  logic [COUNT_W-1:0] prev_count_q, prev_count_d;
  logic               prev_event_q, prev_event_d;
  logic [WRAP_W-1:0]  wrap_epoch_q, wrap_epoch_d;
  logic               wrap_pulse_q, wrap_pulse_d;
  logic               cmp_match_q, cmp_match_d;
  logic               overflow_q, overflow_d;

  logic               wrap_now;
  logic               hit;
  logic               ev_edge;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               drop;
  logic [ENTRY_W-1:0] push_data;

  // Any backwards step (63->0 rollover or a counter reset) advances the epoch.
  always_comb begin
    wrap_now     = primed_q & (count_in < prev_count_q);
    hit          = cmp_en & (count_in == cmp_value) &
                   (~primed_q | (count_in != prev_count_q));
    ev_edge      = event_in & ~prev_event_q;
    fifo_pop     = ~fifo_empty & cap_ready;
    drop         = ev_edge & fifo_full & ~fifo_pop;

    primed_d     = 1'b1;
    prev_count_d = count_in;
    prev_event_d = event_in;
    wrap_epoch_d = wrap_epoch_q + WRAP_W'(wrap_now);
    wrap_pulse_d = wrap_now;
    cmp_match_d  = hit;
    overflow_d   = drop | (overflow_q & ~clear_ovf);
    push_data    = {wrap_epoch_d, count_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      primed_q     <= 1'b0;
      prev_count_q <= '0;
      prev_event_q <= 1'b0;
      wrap_epoch_q <= '0;
      wrap_pulse_q <= 1'b0;
      cmp_match_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      primed_q     <= primed_d;
      prev_count_q <= prev_count_d;
      prev_event_q <= prev_event_d;
      wrap_epoch_q <= wrap_epoch_d;
      wrap_pulse_q <= wrap_pulse_d;
      cmp_match_q  <= cmp_match_d;
      overflow_q   <= overflow_d;
    end
  end

  capture_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (ev_edge),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head_data (cap_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign cap_valid  = ~fifo_empty;
  assign cmp_match  = cmp_match_q;
  assign wrap_pulse = wrap_pulse_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_count_capture_unit.sv
// Directed bench for count_capture_unit with a behavioural model and capture scoreboard.
module tb_count_capture_unit;
  import count_capture_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] count_in;
  logic       event_in;
  logic       cmp_en;
  logic [5:0] cmp_value;
  logic       cap_ready;
  logic       clear_ovf;
  logic       cap_valid;
  logic [9:0] cap_data;
  logic [2:0] fifo_level;
  logic       cmp_match;
  logic       wrap_pulse;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  cap_entry_t sb[$];
  logic       m_primed, m_prev_event, m_ovf;
  logic [5:0] m_prev_count;
  logic [3:0] m_epoch;
  logic       exp_wrap, exp_hit;
  logic [5:0] cnt;

  count_capture_unit dut (
    .clock      (clock),
    .reset      (reset),
    .count_in   (count_in),
    .event_in   (event_in),
    .cmp_en     (cmp_en),
    .cmp_value  (cmp_value),
    .cap_ready  (cap_ready),
    .clear_ovf  (clear_ovf),
    .cap_valid  (cap_valid),
    .cap_data   (cap_data),
    .fifo_level (fifo_level),
    .cmp_match  (cmp_match),
    .wrap_pulse (wrap_pulse),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_primed     = 1'b0;
    m_prev_event = 1'b0;
    m_prev_count = '0;
    m_epoch      = '0;
    m_ovf        = 1'b0;
    exp_wrap     = 1'b0;
    exp_hit      = 1'b0;
    sb.delete();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cap_valid"},  16'(cap_valid),  16'd0);
    chk({tag, "_cap_data"},   16'(cap_data),   16'd0);
    chk({tag, "_fifo_level"}, 16'(fifo_level), 16'd0);
    chk({tag, "_cmp_match"},  16'(cmp_match),  16'd0);
    chk({tag, "_wrap_pulse"}, 16'(wrap_pulse), 16'd0);
    chk({tag, "_overflow"},   16'(overflow),   16'd0);
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic tick(input logic [5:0] c, input logic ev, input logic rdy, input logic clr);
    logic       pop, ev_edge, drop;
    cap_entry_t e;
    count_in  = c;
    event_in  = ev;
    cap_ready = rdy;
    clear_ovf = clr;
    exp_wrap  = m_primed && (c < m_prev_count);
    exp_hit   = cmp_en && (c == cmp_value) && (!m_primed || (c != m_prev_count));
    if (exp_wrap) m_epoch = m_epoch + 4'd1;
    ev_edge = ev && !m_prev_event;
    pop     = rdy && (sb.size() != 0);
    drop    = 1'b0;
    if (pop) begin
      e = sb.pop_front();
      chk("pop_data", 16'(cap_data), 16'(e));
    end
    if (ev_edge) begin
      if (sb.size() < 4) sb.push_back(cap_entry_t'{wrap_epoch: m_epoch, count: c});
      else drop = 1'b1;
    end
    m_ovf        = drop || (m_ovf && !clr);
    m_primed     = 1'b1;
    m_prev_count = c;
    m_prev_event = ev;
    @(posedge clock);
    #1;
    chk("wrap_pulse", 16'(wrap_pulse), 16'(exp_wrap));
    chk("cmp_match",  16'(cmp_match),  16'(exp_hit));
    chk("overflow",   16'(overflow),   16'(m_ovf));
    chk("fifo_level", 16'(fifo_level), 16'(sb.size()));
    chk("cap_valid",  16'(cap_valid),  16'(sb.size() != 0));
    if (sb.size() != 0) chk("cap_data", 16'(cap_data), 16'(sb[0]));
  endtask

  task automatic inc(input logic ev, input logic rdy, input logic clr);
    cnt = cnt + 6'd1;
    tick(cnt, ev, rdy, clr);
  endtask

  initial begin
    reset     = 1'b1;
    count_in  = '0;
    event_in  = 1'b0;
    cmp_en    = 1'b0;
    cmp_value = '0;
    cap_ready = 1'b0;
    clear_ovf = 1'b0;
    model_reset();
    #1;
    check_idle("reset_async");
    repeat (2) @(posedge clock);
    #1;
    check_idle("reset_held");
    @(negedge clock);
    reset = 1'b0;

    cnt = '0;
    tick(cnt, 1'b0, 1'b0, 1'b0);
    cmp_en    = 1'b1;
    cmp_value = 6'd5;

    // Full pass 1..63 then 0: one wrap pulse, epoch 0->1.
    repeat (64) inc(1'b0, 1'b0, 1'b0);
    chk("wrap_after_63", 16'(wrap_pulse), 16'd1);
    chk("epoch_model_1", 16'(m_epoch), 16'd1);

    repeat (5) inc(1'b0, 1'b0, 1'b0);
    chk("cmp_at_5", 16'(cmp_match), 16'd1);
    repeat (10) tick(cnt, 1'b0, 1'b0, 1'b0);
    chk("cmp_hold_5", 16'(cmp_match), 16'd0);

    // Advance to epoch 2, then capture at count 12.
    while (cnt != 6'd63) inc(1'b0, 1'b0, 1'b0);
    inc(1'b0, 1'b0, 1'b0);
    while (cnt != 6'd11) inc(1'b0, 1'b0, 1'b0);
    inc(1'b1, 1'b0, 1'b0);
    chk("cap12_data",  16'(cap_data),   16'({4'd2, 6'd12}));
    chk("cap12_level", 16'(fifo_level), 16'd1);
    repeat (3) inc(1'b0, 1'b0, 1'b0);
    chk("cap12_held", 16'(cap_data), 16'({4'd2, 6'd12}));
    inc(1'b0, 1'b1, 1'b0);

    // Five edges without ready: fifth dropped.
    repeat (5) begin
      inc(1'b1, 1'b0, 1'b0);
      inc(1'b0, 1'b0, 1'b0);
    end
    chk("ovf_set",    16'(overflow),   16'd1);
    chk("ovf_level4", 16'(fifo_level), 16'd4);
    inc(1'b0, 1'b0, 1'b1);
    chk("ovf_clear", 16'(overflow), 16'd0);
    repeat (4) inc(1'b0, 1'b1, 1'b0);

    // Full FIFO with simultaneous push and pop.
    repeat (4) begin
      inc(1'b1, 1'b0, 1'b0);
      inc(1'b0, 1'b0, 1'b0);
    end
    inc(1'b1, 1'b1, 1'b0);
    chk("full_pp_level", 16'(fifo_level), 16'd4);
    chk("full_pp_ovf",   16'(overflow),   16'd0);
    inc(1'b0, 1'b0, 1'b0);
    // Drop and clear together: set wins.
    inc(1'b1, 1'b0, 1'b1);
    chk("ovf_set_wins", 16'(overflow), 16'd1);
    inc(1'b0, 1'b0, 1'b1);
    repeat (4) inc(1'b0, 1'b1, 1'b0);

    // Counter resets drive the epoch to 15, then an edge on a 63->0 wrap.
    tick(6'd63, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16 && m_epoch != 4'd15; i++) begin
      tick(6'd0,  1'b0, 1'b0, 1'b0);
      tick(6'd63, 1'b0, 1'b0, 1'b0);
    end
    chk("epoch_model_15", 16'(m_epoch), 16'd15);
    cnt = 6'd0;
    tick(cnt, 1'b1, 1'b0, 1'b0);
    chk("wrap_edge_entry", 16'(cap_data),  16'({4'd0, 6'd0}));
    chk("wrap_edge_valid", 16'(cap_valid), 16'd1);
    chk("wrap_edge_pulse", 16'(wrap_pulse), 16'd1);
    inc(1'b0, 1'b1, 1'b0);

    // Fill with overflow, start draining, then assert reset between edges.
    repeat (5) begin
      inc(1'b1, 1'b0, 1'b0);
      inc(1'b0, 1'b0, 1'b0);
    end
    inc(1'b0, 1'b1, 1'b0);
    chk("pre_reset_level", 16'(fifo_level), 16'd3);
    #2;
    reset = 1'b1;
    #1;
    check_idle("reset_mid_drain");
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    cnt = 6'd0;
    tick(cnt, 1'b0, 1'b1, 1'b0);
    inc(1'b1, 1'b0, 1'b0);
    inc(1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
